// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad scanner:
//   - state_t               : scanner FSM state encoding
//   - SETTLE_CYCLES_DEFAULT : default per-row settle time in clk cycles
//   - key_map()             : row/column to hex key label
package keypad_pkg;

    localparam int unsigned SETTLE_CYCLES_DEFAULT = 3000;

    typedef enum logic [1:0] {
        ST_START,
        ST_DRIVE,
        ST_EVAL,
        ST_FROZEN
    } state_t;

    // Index is {row, col}; keypad legend:
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: *(E) 0 #(F) D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
//   Two-flop synchronizer for the raw keypad column lines.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset; flops reset to 4'b1111 (idle,
//             pulled-up columns)
//     d_in  - asynchronous column inputs
//     q_out - synchronized columns
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_in,
    output logic [3:0] q_out
);

    logic [3:0] meta_q;
    logic [3:0] meta_d;
    logic [3:0] sync_q;
    logic [3:0] sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Row-sweep scanner for a 4x4 active-low matrix keypad. Each row is driven
//   for SETTLE_CYCLES cycles, the synchronized columns are sampled on the last
//   of those cycles and folded into sweep accumulators in a one-cycle EVAL
//   state. At the end of row 3 the registered outputs are updated. With
//   scan_stop high and a key detected, the sweep freezes on that key's row and
//   keeps re-checking its column.
//   Ports:
//     clk          - system clock (3 MHz nominal)
//     rst_n        - asynchronous active-low reset
//     col_n[3:0]   - raw keypad columns, active-low, asynchronous
//     scan_stop    - freeze the sweep on the detected key's row
//     row_n[3:0]   - one-cold row drive (1111 = no row driven)
//     key_detected - exactly one key pressed
//     key_code     - hex label of the detected key
//     multi_key    - two or more keys pressed in the last sweep
//     sweep_done   - one-cycle pulse at the end of each 4-row sweep
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    input  logic       scan_stop,
    output logic [3:0] row_n,
    output logic       key_detected,
    output logic [3:0] key_code,
    output logic       multi_key,
    output logic       sweep_done
);

    localparam logic [15:0] SAMPLE_CNT = 16'(SETTLE_CYCLES - 1);

    logic [3:0] col_s;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (col_n),
        .q_out (col_s)
    );

    state_t      state_q,        state_d;
    logic [1:0]  row_q,          row_d;
    logic [15:0] cnt_q,          cnt_d;
    logic [3:0]  sample_q,       sample_d;
    logic [1:0]  acc_cnt_q,      acc_cnt_d;
    logic [1:0]  acc_row_q,      acc_row_d;
    logic [1:0]  acc_col_q,      acc_col_d;
    logic [1:0]  key_row_q,      key_row_d;
    logic [1:0]  key_col_q,      key_col_d;
    logic [3:0]  row_n_q,        row_n_d;
    logic        key_detected_q, key_detected_d;
    logic [3:0]  key_code_q,     key_code_d;
    logic        multi_key_q,    multi_key_d;
    logic        sweep_done_q,   sweep_done_d;

    // Result of folding the current row sample into the accumulators.
    logic [1:0]  fold_cnt;
    logic [1:0]  fold_row;
    logic [1:0]  fold_col;
    logic [2:0]  low_cnt;
    logic [2:0]  sum_cnt;
    logic [1:0]  first_col;
    logic        found;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_START;
            row_q          <= '0;
            cnt_q          <= '0;
            sample_q       <= '1;
            acc_cnt_q      <= '0;
            acc_row_q      <= '0;
            acc_col_q      <= '0;
            key_row_q      <= '0;
            key_col_q      <= '0;
            row_n_q        <= '1;
            key_detected_q <= 1'b0;
            key_code_q     <= '0;
            multi_key_q    <= 1'b0;
            sweep_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            sample_q       <= sample_d;
            acc_cnt_q      <= acc_cnt_d;
            acc_row_q      <= acc_row_d;
            acc_col_q      <= acc_col_d;
            key_row_q      <= key_row_d;
            key_col_q      <= key_col_d;
            row_n_q        <= row_n_d;
            key_detected_q <= key_detected_d;
            key_code_q     <= key_code_d;
            multi_key_q    <= multi_key_d;
            sweep_done_q   <= sweep_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample fold: count low columns (saturating at 2) and remember the
    // first low column seen in the sweep.
    // ------------------------------------------------------------------
    always_comb begin
        low_cnt   = '0;
        first_col = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!sample_q[i]) begin
                low_cnt = low_cnt + 3'd1;
                if (!found) begin
                    found     = 1'b1;
                    first_col = 2'(i);
                end
            end
        end
        sum_cnt  = {1'b0, acc_cnt_q} + low_cnt;
        fold_cnt = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        fold_row = acc_row_q;
        fold_col = acc_col_q;
        if (acc_cnt_q == 2'd0 && found) begin
            fold_row = row_q;
            fold_col = first_col;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        cnt_d          = cnt_q;
        sample_d       = sample_q;
        acc_cnt_d      = acc_cnt_q;
        acc_row_d      = acc_row_q;
        acc_col_d      = acc_col_q;
        key_row_d      = key_row_q;
        key_col_d      = key_col_q;
        key_detected_d = key_detected_q;
        key_code_d     = key_code_q;
        multi_key_d    = multi_key_q;
        sweep_done_d   = 1'b0;

        unique case (state_q)
            ST_START: begin
                acc_cnt_d = '0;
                acc_row_d = '0;
                acc_col_d = '0;
                row_d     = '0;
                cnt_d     = '0;
                state_d   = ST_DRIVE;
            end

            ST_DRIVE: begin
                if (cnt_q == SAMPLE_CNT) begin
                    sample_d = col_s;
                    state_d  = ST_EVAL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_EVAL: begin
                cnt_d = '0;
                if (row_q != 2'd3) begin
                    acc_cnt_d = fold_cnt;
                    acc_row_d = fold_row;
                    acc_col_d = fold_col;
                    row_d     = row_q + 2'd1;
                    state_d   = (scan_stop && key_detected_q) ? ST_FROZEN : ST_DRIVE;
                end else begin
                    sweep_done_d = 1'b1;
                    case (fold_cnt)
                        2'd1: begin
                            key_detected_d = 1'b1;
                            key_code_d     = key_map(fold_row, fold_col);
                            multi_key_d    = 1'b0;
                            key_row_d      = fold_row;
                            key_col_d      = fold_col;
                        end
                        2'd0: begin
                            key_detected_d = 1'b0;
                            key_code_d     = '0;
                            multi_key_d    = 1'b0;
                        end
                        default: begin
                            key_detected_d = 1'b0;
                            key_code_d     = '0;
                            multi_key_d    = 1'b1;
                        end
                    endcase
                    acc_cnt_d = '0;
                    acc_row_d = '0;
                    acc_col_d = '0;
                    row_d     = '0;
                    // The sweep-boundary freeze decision uses the freshly
                    // evaluated result, so a key released in this sweep
                    // never freezes the scanner.
                    state_d   = (scan_stop && fold_cnt == 2'd1) ? ST_FROZEN : ST_DRIVE;
                end
            end

            ST_FROZEN: begin
                if (!scan_stop) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else if (cnt_q == SAMPLE_CNT) begin
                    cnt_d = '0;
                    if (col_s[key_col_q]) begin
                        key_detected_d = 1'b0;
                        key_code_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: state_d = ST_START;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: row drive is decoded from the next state so row_n is
    // a registered output aligned with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        row_n_d = '1;
        unique case (state_d)
            ST_DRIVE,
            ST_EVAL:   row_n_d = ~(4'b0001 << row_d);
            ST_FROZEN: row_n_d = ~(4'b0001 << key_row_d);
            default:   row_n_d = '1;
        endcase
    end

    assign row_n        = row_n_q;
    assign key_detected = key_detected_q;
    assign key_code     = key_code_q;
    assign multi_key    = multi_key_q;
    assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SETTLE_CYCLES=4 (20-cycle sweep).
//   A behavioural keypad matrix pulls col_n[c] low while row r is driven and
//   key (r,c) is held.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_n;
    logic       scan_stop;
    logic [3:0] row_n;
    logic       key_detected;
    logic [3:0] key_code;
    logic       multi_key;
    logic       sweep_done;

    // pressed[r*4+c] = key at row r, column c is held
    logic [15:0] pressed;

    int vectors;
    int miscompares;

    keypad_scanner #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_n        (col_n),
        .scan_stop    (scan_stop),
        .row_n        (row_n),
        .key_detected (key_detected),
        .key_code     (key_code),
        .multi_key    (multi_key),
        .sweep_done   (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until sweep_done is seen (sampled 1 time unit after posedge).
    // Returns the number of edges taken, or -1 on timeout.
    task automatic wait_sd(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!sweep_done && cycles < 100);
        if (!sweep_done) cycles = -1;
    endtask

    initial begin
        int n;
        int sd_cnt;
        int row_bad;
        int kd_bad;
        int early;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        scan_stop   = 1'b0;
        pressed     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_n",   32'(row_n),        32'hF);
        chk("rst_kd",      32'(key_detected), 32'h0);
        chk("rst_code",    32'(key_code),     32'h0);
        chk("rst_multi",   32'(multi_key),    32'h0);
        chk("rst_sd",      32'(sweep_done),   32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (row_n !== 4'hE && n < 2);
        chk("rst_row0_start", 32'(row_n), 32'hE);

        // ---------------- idle sweeps ----------------
        early = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (key_detected || multi_key) early++;
        end while (!sweep_done && n < 100);
        chk("idle_first_sd",   32'(sweep_done), 32'h1);
        chk("idle_no_early",   32'(early),      32'h0);
        @(posedge clk); #1;
        chk("sd_one_cycle",    32'(sweep_done), 32'h0);
        wait_sd(n);
        chk("idle_period",     32'(n + 1),      32'd20);
        chk("idle_kd",         32'(key_detected), 32'h0);

        // ---------------- key 5 (row1 col1) ----------------
        pressed = 16'h0020;
        wait_sd(n);
        wait_sd(n);
        chk("k5_sd",    32'(n),            32'd20);
        chk("k5_kd",    32'(key_detected), 32'h1);
        chk("k5_code",  32'(key_code),     32'h5);
        chk("k5_multi", 32'(multi_key),    32'h0);

        // ---------------- keys 1 and 6 ----------------
        pressed = 16'h0041;
        wait_sd(n);
        chk("multi_kd",    32'(key_detected), 32'h0);
        chk("multi_code",  32'(key_code),     32'h0);
        chk("multi_multi", 32'(multi_key),    32'h1);
        pressed = '0;
        wait_sd(n);
        chk("rel_multi",   32'(multi_key),    32'h0);
        chk("rel_kd",      32'(key_detected), 32'h0);

        // ---------------- key 0 (row3 col1) ----------------
        pressed = 16'h2000;
        wait_sd(n);
        chk("k0_kd",    32'(key_detected), 32'h1);
        chk("k0_code",  32'(key_code),     32'h0);
        chk("k0_multi", 32'(multi_key),    32'h0);

        // ---------------- key 9 (row2 col2) and freeze ----------------
        pressed = 16'h0400;
        wait_sd(n);
        chk("k9_kd",   32'(key_detected), 32'h1);
        chk("k9_code", 32'(key_code),     32'h9);
        scan_stop = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        sd_cnt  = 0;
        row_bad = 0;
        kd_bad  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sweep_done) sd_cnt++;
            if (row_n !== 4'hB) row_bad++;
            if (key_detected !== 1'b1) kd_bad++;
        end
        chk("frz_row_n",  32'(row_n),  32'hB);
        chk("frz_row_bad", 32'(row_bad), 32'h0);
        chk("frz_no_sd",  32'(sd_cnt),  32'h0);
        chk("frz_kd_held", 32'(kd_bad), 32'h0);

        pressed = '0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (key_detected && n < 6);
        chk("frz_rel_kd",   32'(key_detected), 32'h0);
        chk("frz_rel_code", 32'(key_code),     32'h0);

        scan_stop = 1'b0;
        @(posedge clk); #1;
        chk("unfrz_start_row", 32'(row_n), 32'hF);
        @(posedge clk); #1;
        chk("unfrz_row0",      32'(row_n), 32'hE);

        // ---------------- scan_stop ignored without a key ----------------
        scan_stop = 1'b1;
        wait_sd(n);
        wait_sd(n);
        chk("stop_idle_period", 32'(n), 32'd20);
        chk("stop_idle_kd",     32'(key_detected), 32'h0);
        scan_stop = 1'b0;

        // ---------------- reset mid-row 2 ----------------
        pressed = 16'h0020;
        wait_sd(n);
        wait_sd(n);
        chk("pre_rst_kd", 32'(key_detected), 32'h1);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_row2", 32'(row_n), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_n", 32'(row_n),        32'hF);
        chk("mid_rst_kd",    32'(key_detected), 32'h0);
        chk("mid_rst_code",  32'(key_code),     32'h0);
        chk("mid_rst_multi", 32'(multi_key),    32'h0);
        chk("mid_rst_sd",    32'(sweep_done),   32'h0);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (row_n !== 4'hE && n < 2);
        chk("post_rst_row0", 32'(row_n), 32'hE);
        wait_sd(n);
        chk("post_rst_sd", 32'(sweep_done),   32'h1);
        chk("post_rst_kd", 32'(key_detected), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3000, meaning clk cycles each row is driven before its columns are sampled (1 ms at 3 MHz); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock, 3 MHz nominal.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port col_n  input  4  raw keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-005 SHALL have port scan_stop  input  1  freeze the sweep on the row of the currently detected key.
REQ-006 SHALL have port row_n  output  4  keypad row drive, one-cold; a 0 bit drives that row.
REQ-007 SHALL have port key_detected  output  1  exactly one key is pressed.
REQ-008 SHALL have port key_code  output  4  hex label of the detected key.
REQ-009 SHALL have port multi_key  output  1  two or more keys were pressed in the last sweep.
REQ-010 SHALL have port sweep_done  output  1  one-cycle pulse at the end of each 4-row sweep.

Function
REQ-011 SHALL pass col_n through a 2-FF synchronizer before any use; the synchronized value is col_s.
REQ-012 SHALL use a settle counter 0..SETTLE_CYCLES-1 per row; col_s is sampled on the cycle where the count equals SETTLE_CYCLES-1.
REQ-013 SHALL use FSM states START, DRIVE, EVAL, FROZEN.
REQ-014 START: row_n=4'b1111; clear sweep accumulators; go to DRIVE with row 0 on the next cycle.
REQ-015 DRIVE: row_n drives the current row; the settle counter increments; at the sample count, go to EVAL.
REQ-016 EVAL (one cycle): fold the sample into the sweep accumulators, which hold the count of low columns (saturating at 2) and the row/column of the first low column.
REQ-017 EVAL on rows 0..2: advance to the next row, reset the counter, and return to DRIVE.
REQ-018 EVAL on row 3: pulse sweep_done and update the outputs as follows.
 - count==1: key_detected=1, key_code=map, multi_key=0.
 - count==0: all three outputs 0.
 - count==2: key_detected=0, key_code=0, multi_key=1.
 - Then clear the accumulators and restart at row 0.
REQ-019 Key map, row r / col c: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D; col_n bit c corresponds to column c.
REQ-020 key_code 4'h0 with key_detected=1 is a valid "0" key; key_code is meaningful only while key_detected=1.
REQ-021 Outputs SHALL be registered and change only at the end of a sweep (or in FROZEN, per REQ-023).
 - Latency from a stable press to key_detected is at most 2 full sweeps.
 - Full sweep = 4*(SETTLE_CYCLES+1) cycles.
REQ-022 When scan_stop=1 and key_detected=1 at an EVAL or sweep boundary, SHALL enter FROZEN.
 - row_n drives the latched key's row.
 - The latched column is resampled every SETTLE_CYCLES cycles.
 - sweep_done does not pulse.
REQ-023 FROZEN: if the latched column samples high, SHALL clear key_detected and key_code on the next cycle.
REQ-024 FROZEN: when scan_stop falls, SHALL go to START; the first full sweep after START re-evaluates all outputs.
REQ-025 scan_stop=1 while key_detected=0 SHALL be ignored and the sweep continues.
REQ-026 Counter wrap SHALL be impossible: counter width is 16 bits and the counter resets on every row change.

Reset
REQ-027 rst_n low SHALL asynchronously force the following, regardless of the state in progress:
 - state=START, row_n=4'b1111;
 - key_detected=0, key_code=0, multi_key=0, sweep_done=0;
 - settle counter, accumulators and synchronizer flops = 0/idle (synchronizer flops = 4'b1111).
REQ-028 After rst_n rises, the first row-0 drive SHALL begin within 2 cycles; no output asserts before the first sweep completes.

Structure
REQ-029 SHALL import the shared package keypad_pkg, which holds:
 - the state typedef;
 - the key-map constant/function;
 - the SETTLE_CYCLES default.
REQ-030 SHALL instantiate one sub-module keypad_sync (4-bit 2-FF synchronizer, reset to 4'b1111); all other logic stays in keypad_scanner.

Verification (SETTLE_CYCLES=4, sweep=20 cycles)
REQ-031 Key 5 held (col_n bit1 low while row_n=4'b1101) -> after 2 sweeps: key_detected=1, key_code=4'h5, multi_key=0.
REQ-032 Keys 1 and 6 held -> at the next sweep_done: key_detected=0, key_code=0, multi_key=1; release both -> multi_key=0 after one sweep.
REQ-033 Key 9 held, then scan_stop=1 -> row_n stays 4'b1011 and no sweep_done; release 9 -> key_detected=0 within 6 cycles; scan_stop=0 -> row_n=4'b1111 for one cycle, then row 0 is driven.
REQ-034 Key 0 held (row3, col1) -> key_detected=1, key_code=4'h0.
REQ-035 No keys pressed -> sweep_done pulses every 20 cycles and key_detected stays 0; rst_n pulsed mid-row 2 -> all outputs 0 and row_n=4'b1111 immediately, next sweep starts at row 0.
